// File: rtl/pipelined_cla_subtractor_if.sv
// pipelined_cla_subtractor_if: operand and result valid/ready bundle for the pipelined subtractor
interface pipelined_cla_subtractor_if #(
  parameter int NUMBITS = 8
);
  logic in_valid, in_ready, bw_in, out_valid, out_ready, bw_out, ovf_out;
  logic [NUMBITS-1:0] a_in, b_in, d_out;
  modport master(
    output in_valid, a_in, b_in, bw_in, out_ready,
    input in_ready, out_valid, d_out, bw_out, ovf_out
  );
  modport slave(
    input in_valid, a_in, b_in, bw_in, out_ready,
    output in_ready, out_valid, d_out, bw_out, ovf_out
  );
endinterface

// File: rtl/pipelined_cla_subtractor.sv
// pipelined_cla_subtractor: valid/ready pipelined a - b - bw_in resolving one carry-lookahead group per stage
module pipelined_cla_subtractor #(
  parameter int NUMBITS = 8,
  parameter int GROUP = 4
) (
  input logic clk,
  input logic reset,
  pipelined_cla_subtractor_if.slave io
);
  localparam int STAGES = NUMBITS / GROUP;
  localparam int L = STAGES - 1;
  if (NUMBITS % GROUP != 0 || NUMBITS < GROUP) begin : g_chk
    $error("NUMBITS must be a positive multiple of GROUP");
  end
  function automatic logic [GROUP-1:0] lo(input int n);
    return GROUP'((1 << n) - 1);
  endfunction
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic v_q, v_d, c_q, c_d, adv, ld, vi, ci;
    logic [1:0] m_q, m_d, mi;
    logic [NUMBITS-1:0] s_q, s_d, y_q, y_d, si, yi;
    logic [GROUP-1:0] p, g;
    logic [GROUP:0] cc;
    if (k == 0) begin : g_src
      assign {vi, ci, mi, si, yi} = {io.in_valid, ~io.bw_in, io.a_in[NUMBITS-1], io.b_in[NUMBITS-1], io.a_in, ~io.b_in};
    end else begin : g_src
      assign {vi, ci, mi, si, yi} = {g_st[k-1].v_q, g_st[k-1].c_q, g_st[k-1].m_q, g_st[k-1].s_q, g_st[k-1].y_q};
    end
    if (k == L) begin : g_adv
      assign adv = !v_q || io.out_ready;
    end else begin : g_adv
      assign adv = !v_q || g_st[k+1].adv;
    end
    always_comb begin
      ld = adv && vi;
      p = si[k*GROUP +: GROUP] ^ yi[k*GROUP +: GROUP];
      g = si[k*GROUP +: GROUP] & yi[k*GROUP +: GROUP];
      for (int i = 0; i <= GROUP; i++) begin
        cc[i] = ci && ((p | ~lo(i)) == '1);
        for (int j = 0; j < i; j++) cc[i] = cc[i] || (g[j] && ((p | ~lo(i) | lo(j + 1)) == '1));
      end
      s_d = si;
      s_d[k*GROUP +: GROUP] = p ^ cc[GROUP-1:0];
      s_d = ld ? s_d : s_q;
      y_d = ld ? yi : y_q;
      c_d = ld ? cc[GROUP] : c_q;
      m_d = ld ? mi : m_q;
      v_d = adv ? vi : v_q;
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= 1'b0;
        c_q <= 1'b1;
        m_q <= '0;
        s_q <= '0;
        y_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        m_q <= m_d;
        s_q <= s_d;
        y_q <= y_d;
      end
    end
  end
  assign io.in_ready = g_st[0].adv;
  assign io.out_valid = g_st[L].v_q;
  assign io.d_out = g_st[L].s_q;
  assign io.bw_out = !g_st[L].c_q;
  assign io.ovf_out = (g_st[L].m_q[1] != g_st[L].m_q[0]) && (g_st[L].s_q[NUMBITS-1] != g_st[L].m_q[1]);
endmodule
